// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, baud period table and counter width for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} uart_rx_state_e;

    localparam int UART_CNT_W = 13;

    localparam logic [UART_CNT_W-1:0] BAUD_PERIOD [8] = '{
        13'd100, 13'd200, 13'd400, 13'd600, 13'd1200, 13'd2400, 13'd4800, 13'd4800
    };

    function automatic logic [UART_CNT_W-1:0] half_period(input logic [2:0] baud);
        return BAUD_PERIOD[baud] >> 1;
    endfunction

endpackage

// File: rtl/uart_rx_multi_if.sv
// uart_rx_multi_if: received-word valid/ready stream toward the command parser
interface uart_rx_multi_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received words until the consumer takes them
module uart_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push_ok, pop_ok;

    // Flags and accepted transfers; a full FIFO still takes a push when a pop frees a slot in the same cycle
    always_comb begin
        empty   = count == '0;
        full    = count == (AW+1)'(DEPTH);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        dout    = empty ? '0 : mem[rd_ptr];
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap on their own
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Word storage, written only on an accepted push
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_rx_multi.sv
// uart_rx_multi: UART receiver with runtime baud, 1/2 stop bits and output FIFO; parity bit present when UART_RX_PARITY_EN is defined
module uart_rx_multi
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [2:0]      i_baud,
    input  logic            i_stop2,
    input  logic            i_rx,
    uart_rx_multi_if.master rx_bus,
    output logic            o_frame_err,
    output logic            o_parity_err,
    output logic            o_overrun,
    output logic            o_busy
);
`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_e AFTER_DATA = PARITY;
`else
    localparam uart_rx_state_e AFTER_DATA = STOP1;
`endif

    uart_rx_state_e         state, state_n;
    logic [SYNC_STAGES:0]   sync;
    logic [UART_CNT_W-1:0]  cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_W-1:0]      sh;
    logic [2:0]             baud_l;
    logic                   stop2_l, par_bad, push, full, empty;
    logic                   rx_s, start_edge, tick, stop_smp, frame_bad, frame_end;

    assign rx_s       = sync[SYNC_STAGES-1];
    assign start_edge = sync[SYNC_STAGES] && !rx_s;
    assign tick       = cnt == '0;

    // Synchroniser plus one extra stage so a falling edge is seen only after the line was high
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) sync <= '1;
        else sync <= {sync[SYNC_STAGES-1:0], i_rx};
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else state <= state_n;
    end

    // Next-state: every decision happens on the mid-bit sample tick
    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (start_edge) state_n = START;
            START:  if (tick) state_n = rx_s ? IDLE : DATA;
            DATA:   if (tick && bit_cnt == 4'(DATA_W-1)) state_n = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) state_n = STOP1;
`endif
            STOP1:  if (tick) state_n = (!rx_s || !stop2_l) ? IDLE : STOP2;
            STOP2:  if (tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from state: busy flag and end-of-frame verdicts
    always_comb begin
        o_busy    = state != IDLE;
        stop_smp  = tick && (state == STOP1 || state == STOP2);
        frame_bad = stop_smp && !rx_s;
        frame_end = stop_smp && rx_s && (state == STOP2 || !stop2_l);
    end

    // Sampling counter, shift register, latched settings and one-cycle error pulses
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt          <= '0;
            bit_cnt      <= '0;
            sh           <= '0;
            baud_l       <= '0;
            stop2_l      <= 1'b0;
            par_bad      <= 1'b0;
            push         <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            push        <= frame_end && !par_bad;
            o_frame_err <= frame_bad;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= frame_end && par_bad;
`else
            o_parity_err <= 1'b0;
`endif
            if (state == IDLE) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
                if (start_edge) begin
                    baud_l  <= i_baud;
                    stop2_l <= i_stop2;
                    cnt     <= half_period(i_baud) - 1'b1;
                end
            end else if (tick) begin
                cnt <= BAUD_PERIOD[baud_l] - 1'b1;
                if (state == DATA) begin
                    sh      <= {rx_s, sh[DATA_W-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (state == PARITY) par_bad <= rx_s != (^sh ^ 1'(PARITY_ODD));
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    uart_rx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (push),
        .din   (sh),
        .pop   (rx_bus.ready),
        .dout  (rx_bus.data),
        .full  (full),
        .empty (empty)
    );

    assign rx_bus.valid = !empty;
    assign o_overrun    = push && full && !rx_bus.ready;
endmodule
